// File: rtl/alu_issue_wb.sv
// Operand-fetch / issue / write-back stage around an 8-bit combinational ALU.
// Optional macro ALU_CMP_NOWB_EN: compare opcode updates zero_flag only, no register write.
module alu_issue_wb #(
    parameter int unsigned    DATA_W = 8,
    parameter int unsigned    RA_W   = 3,
    parameter int unsigned    OP_W   = 4,
    parameter logic [OP_W-1:0] CMP_OP = 4'b1001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              rf_wr_en,
    input  logic [RA_W-1:0]   rf_wr_addr,
    input  logic [DATA_W-1:0] rf_wr_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              zero_flag,
    output logic              done,
    output logic              busy
);

    localparam int unsigned NREG = 2 ** RA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] rf [NREG];
    logic [RA_W-1:0]   rd_q;

    logic [OP_W-1:0]   op_f;
    logic [RA_W-1:0]   rd_f, rs1_f, rs2_f;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic              accept_c, host_wr_c, wb_en_c, nowb_c;
    logic              unused_instr;

    assign op_f  = instr[15:12];
    assign rd_f  = instr[11:9];
    assign rs1_f = instr[8:6];
    assign rs2_f = instr[5:3];
    assign unused_instr = ^instr[2:0];

    // r0 is hardwired to zero on every read port
    assign rs1_val  = (rs1_f == '0)    ? '0 : rf[rs1_f];
    assign rs2_val  = (rs2_f == '0)    ? '0 : rf[rs2_f];
    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

`ifdef ALU_CMP_NOWB_EN
    assign nowb_c = (alu_opcode == CMP_OP);
`else
    logic unused_cmp;
    assign unused_cmp = (alu_opcode == CMP_OP);
    assign nowb_c     = 1'b0;
`endif

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept_c    = (state == IDLE) && instr_valid;
    assign host_wr_c   = (state == IDLE) && !instr_valid && rf_wr_en && (rf_wr_addr != '0);
    assign wb_en_c     = (state == EXEC) && (rd_q != '0) && !nowb_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue registers: opcode/operands to the ALU, destination, completion status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_q       <= '0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == EXEC);
            if (accept_c) begin
                alu_opcode <= op_f;
                alu_a      <= rs1_val;
                alu_b      <= rs2_val;
                rd_q       <= rd_f;
            end
            if (state == EXEC) begin
                zero_flag <= alu_zero;
            end
        end
    end

    // Register file: write-back (EXEC only) and host preload (IDLE only) never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en_c) begin
            rf[rd_q] <= alu_result;
        end else if (host_wr_c) begin
            rf[rf_wr_addr] <= rf_wr_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with an adder ALU model.
module tb_alu_issue_wb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [15:0] instr = '0;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       alu_zero;
    logic       rf_wr_en = 1'b0;
    logic [2:0] rf_wr_addr = '0;
    logic [7:0] rf_wr_data = '0;
    logic [2:0] dbg_addr = '0;
    logic [7:0] dbg_data;
    logic       zero_flag, done, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       z;
        logic [7:0] dbg;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign alu_result = alu_a + alu_b;
    assign alu_zero   = (alu_result == 8'h00);

    alu_issue_wb dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .zero_flag(zero_flag), .done(done), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        rf_wr_en = 1'b1; rf_wr_addr = addr; rf_wr_data = data;
        @(negedge clk);
        rf_wr_en = 1'b0;
    endtask

    task automatic dbg_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
        @(negedge clk);
        dbg_addr = addr;
        #1 check(name, 32'(dbg_data), 32'(exp));
    endtask

    // Issue one instruction and check the ready/done envelope; results go via the scoreboard
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] ea, input logic [7:0] eb,
                         input logic ez, input logic [7:0] edbg, input logic coinc_wr);
        int low_cnt;
        int done_cnt;
        sb_q.push_back('{op: op, a: ea, b: eb, z: ez, dbg: edbg});
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {op, rd, rs1, rs2, 3'b101};
        dbg_addr = rd;
        if (coinc_wr) begin
            rf_wr_en = 1'b1; rf_wr_addr = 3'd7; rf_wr_data = 8'h55;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rf_wr_en = 1'b0;
        instr = 16'hFFFF;
        low_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_ready) break;
            low_cnt++;
            if (done) done_cnt++;
        end
        check("ready_low_cycles", 32'(low_cnt), 32'd2);
        check("done_pulse_cycles", 32'(done_cnt), 32'd1);
    endtask

    // Monitor: every done pulse pops one expected completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("alu_opcode", 32'(alu_opcode), 32'(e.op));
                    check("alu_a", 32'(alu_a), 32'(e.a));
                    check("alu_b", 32'(alu_b), 32'(e.b));
                    check("zero_flag", 32'(zero_flag), 32'(e.z));
                    check("wb_dbg_data", 32'(dbg_data), 32'(e.dbg));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        // Reset state
        #12 rst_n = 1'b1;
        @(negedge clk);
        check("rst_instr_ready", 32'(instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero_flag", 32'(zero_flag), 32'd0);
        check("rst_alu_ops", 32'({alu_opcode, alu_a, alu_b}), 32'd0);

        // Preload and add
        preload(3'd1, 8'h12);
        preload(3'd2, 8'h34);
        issue(4'h0, 3'd3, 3'd1, 3'd2, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        dbg_check("r3_after_add", 3'd3, 8'h46);

        // Wrap to zero, with a host write coinciding with the accept edge
        preload(3'd1, 8'hFF);
        preload(3'd2, 8'h01);
        issue(4'h0, 3'd4, 3'd1, 3'd2, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1);
        dbg_check("r7_coincident_wr_dropped", 3'd7, 8'h00);

        // r0 rules
        preload(3'd5, 8'h07);
        issue(4'h0, 3'd0, 3'd0, 3'd5, 8'h00, 8'h07, 1'b0, 8'h00, 1'b0);
        preload(3'd0, 8'hAA);
        dbg_check("r0_host_wr_ignored", 3'd0, 8'h00);
        dbg_check("r5_intact", 3'd5, 8'h07);

        // Back-to-back with dependency on r3
        sb_q.push_back('{op: 4'h0, a: 8'hFF, b: 8'h07, z: 1'b0, dbg: 8'h06});
        sb_q.push_back('{op: 4'h2, a: 8'h06, b: 8'h06, z: 1'b0, dbg: 8'h0C});
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {4'h0, 3'd3, 3'd1, 3'd5, 3'b000};
        dbg_addr = 3'd3;
        @(posedge clk);
        #1 instr = {4'h2, 3'd6, 3'd3, 3'd3, 3'b000};
        gap = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                gap = i;
                break;
            end
        end
        check("b2b_accept_gap", 32'(gap), 32'd3);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        dbg_addr = 3'd6;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instr_ready && !busy && i > 0) break;
        end

        // Compare opcode
        preload(3'd1, 8'h80);
        preload(3'd2, 8'h80);
`ifdef ALU_CMP_NOWB_EN
        issue(4'h9, 3'd6, 3'd1, 3'd2, 8'h80, 8'h80, 1'b1, 8'h0C, 1'b0);
`else
        issue(4'h9, 3'd6, 3'd1, 3'd2, 8'h80, 8'h80, 1'b1, 8'h00, 1'b0);
`endif

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {4'h3, 3'd7, 3'd1, 3'd2, 3'b000};
        dbg_addr = 3'd7;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("midop_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midop_rst_alu_ops", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        check("midop_rst_zero_flag", 32'(zero_flag), 32'd0);
        check("midop_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midop_ready_after_rel", 32'(instr_ready), 32'd1);
        check("midop_r7_not_written", 32'(dbg_data), 32'd0);
        repeat (3) @(negedge clk);
        check("midop_no_done", 32'(done), 32'd0);

        // Normal operation after reset
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(4'h3, 3'd2, 3'd1, 3'd2, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
